button_conditioner: RTL



---
 rtl/button_conditioner.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce, auto-repeat and arbitrate the
// five active-low game buttons into one-hot single-cycle press pulses.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic keyLeft_n,
  input  logic keyRight_n,
  input  logic keyUp_n,
  input  logic keyDown_n,
  input  logic keySelect_n,
  output logic btnLeft,
  output logic btnRight,
  output logic btnUp,
  output logic btnDown,
  output logic btnSelect
);

  // Button index map: 0 Left, 1 Right, 2 Up, 3 Down, 4 Select.
  localparam int NB  = 5;
  localparam int NDIR = 4;

  localparam int MAX_DR =
    (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
    DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP =
    (MAX_DR > REPEAT_PERIOD) ?
    MAX_DR : REPEAT_PERIOD;
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] DB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LOAD =
    CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RP_LOAD =
    CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE =
    CW'(1);
  localparam logic REP_EN =
    (REPEAT_DELAY != 0);

  logic [NB-1:0]   w_raw_n;
  logic [NB-1:0]   r_sync1;
  logic [NB-1:0]   r_sync2;
  logic [NB-1:0]   r_stable;
  logic [NB-1:0]   r_stable_q;
  logic [CW-1:0]   r_db_cnt [NB];
  logic [NB-1:0]   w_press;
  logic [CW-1:0]   r_rep_cnt [NDIR];
  logic [NDIR-1:0] r_rep_arm;
  logic [NDIR-1:0] w_rep;
  logic [NB-1:0]   w_cand;
  logic [NB-1:0]   w_grant;
  logic [NB-1:0]   r_btn;

  assign w_raw_n = {
    keySelect_n,
    keyDown_n,
    keyUp_n,
    keyRight_n,
    keyLeft_n
  };

  // Two-flop synchroniser, inverting to active-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~w_raw_n;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level after enough mismatching cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable <= '0;
      for (int i = 0; i < NB; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of stable for rising-edge (press) detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stable_q <= '0;
    end else begin
      r_stable_q <= r_stable;
    end
  end

  assign w_press = r_stable & ~r_stable_q;

  // Repeat fires on the cycle the countdown would hit zero.
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < NDIR; i++) begin
      w_rep[i] = r_stable[i] & r_rep_arm[i] &
                 (r_rep_cnt[i] == CNT_ONE);
    end
  end

  // Per-direction repeat countdown; release clears it at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_arm <= '0;
      for (int i = 0; i < NDIR; i++) begin
        r_rep_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NDIR; i++) begin
        if (!r_stable[i]) begin
          r_rep_cnt[i] <= '0;
          r_rep_arm[i] <= 1'b0;
        end else if (w_press[i]) begin
          r_rep_cnt[i] <= RD_LOAD;
          r_rep_arm[i] <= REP_EN;
        end else if (r_rep_arm[i]) begin
          if (w_rep[i]) begin
            r_rep_cnt[i] <= RP_LOAD;
          end else begin
            r_rep_cnt[i] <= r_rep_cnt[i] - 1'b1;
          end
        end
      end
    end
  end

  assign w_cand = {
    w_press[4],
    w_press[NDIR-1:0] | w_rep
  };

  // Fixed priority: Select > Up > Down > Left > Right; losers drop.
  always_comb begin
    w_grant = '0;
    if (w_cand[4]) begin
      w_grant[4] = 1'b1;
    end else if (w_cand[2]) begin
      w_grant[2] = 1'b1;
    end else if (w_cand[3]) begin
      w_grant[3] = 1'b1;
    end else if (w_cand[0]) begin
      w_grant[0] = 1'b1;
    end else if (w_cand[1]) begin
      w_grant[1] = 1'b1;
    end
  end

  // Registered one-hot output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btn <= '0;
    end else begin
      r_btn <= w_grant;
    end
  end

  assign btnLeft   = r_btn[0];
  assign btnRight  = r_btn[1];
  assign btnUp     = r_btn[2];
  assign btnDown   = r_btn[3];
  assign btnSelect = r_btn[4];

endmodule
